// File: rtl/line_buffer_ctrl_if.sv
// Pixel beat handshake between a video source and the line buffer controller.
interface line_buffer_ctrl_if;
  logic in_valid;
  logic in_sof;
  logic in_ready;

  modport master (output in_valid, output in_sof, input in_ready);
  modport slave  (input in_valid, input in_sof, output in_ready);
endinterface

// File: rtl/line_buffer_ctrl.sv
// Line buffer chain controller: sequences prime/run/flush of a KSIZE-row
// kernel window over a frame and flags window validity and borders.
module line_buffer_ctrl #(
  parameter int unsigned PIXCNT = 8,
  parameter int unsigned COLS   = 2448,
  parameter int unsigned ROWS   = 2048,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned DEPTH  = COLS / PIXCNT,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned RW    = $clog2(ROWS + 1),
  localparam int unsigned TW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cfg_cols,
  input  logic [RW-1:0] cfg_rows,
  line_buffer_ctrl_if.slave pix,
  output logic          lb_enable,
  output logic [TW-1:0] lb_tap_N,
  output logic          pad_sel,
  output logic          win_valid,
  output logic          win_first_row,
  output logic          win_last_row,
  output logic          win_first_col,
  output logic          win_last_col,
  output logic          busy,
  output logic          done,
  output logic          err_cfg,
  output logic          err_sync
);

  localparam int unsigned HALF = (KSIZE - 1) / 2;
  // Row counter runs HALF rows past the frame while flushing.
  localparam int unsigned RCW  = $clog2(ROWS + HALF + 1);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, FLUSH, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cols_q;
  logic [RW-1:0]  rows_q;
  logic [CW-1:0]  col_cnt;
  logic [RCW-1:0] row_cnt;

  logic           accept_c;
  logic           sof_err_c;
  logic           adv_c;
  logic           win_c;
  logic           col_wrap_c;
  logic           cfg_ok_c;
  logic [RCW-1:0] row_inc_c;

  assign pix.in_ready = (state == PRIME) || (state == RUN);
  assign accept_c     = pix.in_valid & pix.in_ready;
  assign pad_sel      = (state == FLUSH);
  assign lb_enable    = accept_c | pad_sel;
  assign busy         = (state != IDLE);

  // A sof beat away from the frame origin restarts the frame instead of advancing.
  assign sof_err_c  = accept_c & pix.in_sof & ((row_cnt != '0) | (col_cnt != '0));
  assign adv_c      = lb_enable & ~sof_err_c;
  assign win_c      = ((state == RUN) & adv_c) | pad_sel;
  assign col_wrap_c = (col_cnt == cols_q - CW'(1));
  assign row_inc_c  = row_cnt + RCW'(1);

  assign cfg_ok_c = (cfg_cols >= CW'(2)) && (cfg_cols <= CW'(DEPTH)) &&
                    (cfg_rows > RW'(HALF)) && (cfg_rows <= RW'(ROWS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cols_q        <= '0;
      rows_q        <= '0;
      col_cnt       <= '0;
      row_cnt       <= '0;
      lb_tap_N      <= '0;
      win_valid     <= 1'b0;
      win_first_row <= 1'b0;
      win_last_row  <= 1'b0;
      win_first_col <= 1'b0;
      win_last_col  <= 1'b0;
      done          <= 1'b0;
      err_cfg       <= 1'b0;
      err_sync      <= 1'b0;
    end else begin
      win_valid     <= 1'b0;
      win_first_row <= 1'b0;
      win_last_row  <= 1'b0;
      win_first_col <= 1'b0;
      win_last_col  <= 1'b0;
      done          <= 1'b0;
      err_cfg       <= 1'b0;
      err_sync      <= 1'b0;

      // Window position is the counter value before this beat advances it.
      if (win_c) begin
        win_valid     <= 1'b1;
        win_first_row <= (row_cnt == RCW'(HALF));
        win_last_row  <= (row_cnt == RCW'(rows_q) + RCW'(HALF - 1));
        win_first_col <= (col_cnt == '0);
        win_last_col  <= col_wrap_c;
      end

      if (adv_c) begin
        if (col_wrap_c) begin
          col_cnt <= '0;
          row_cnt <= row_inc_c;
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok_c) begin
              cols_q   <= cfg_cols;
              rows_q   <= cfg_rows;
              lb_tap_N <= TW'(cfg_cols - CW'(2));
              col_cnt  <= '0;
              row_cnt  <= '0;
              state    <= PRIME;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        PRIME: begin
          if (adv_c && col_wrap_c && (row_inc_c == RCW'(HALF))) state <= RUN;
        end
        RUN: begin
          if (adv_c && col_wrap_c && (row_inc_c == RCW'(rows_q))) state <= FLUSH;
        end
        FLUSH: begin
          if (col_wrap_c && (row_inc_c == RCW'(rows_q) + RCW'(HALF))) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // The misplaced sof beat becomes column 0 of a fresh frame.
      if (sof_err_c) begin
        err_sync <= 1'b1;
        state    <= PRIME;
        row_cnt  <= '0;
        col_cnt  <= CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed self-checking bench for line_buffer_ctrl (default parameters, KSIZE=3).
module tb_line_buffer_ctrl;

  localparam int unsigned DEPTH = 2448 / 8;
  localparam int unsigned ROWS  = 2048;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned RW    = $clog2(ROWS + 1);
  localparam int unsigned TW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_cols = '0;
  logic [RW-1:0] cfg_rows = '0;
  logic          lb_enable, pad_sel, win_valid, busy, done, err_cfg, err_sync;
  logic          win_first_row, win_last_row, win_first_col, win_last_col;
  logic [TW-1:0] lb_tap_N;

  line_buffer_ctrl_if pix ();

  line_buffer_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_cols      (cfg_cols),
    .cfg_rows      (cfg_rows),
    .pix           (pix),
    .lb_enable     (lb_enable),
    .lb_tap_N      (lb_tap_N),
    .pad_sel       (pad_sel),
    .win_valid     (win_valid),
    .win_first_row (win_first_row),
    .win_last_row  (win_last_row),
    .win_first_col (win_first_col),
    .win_last_col  (win_last_col),
    .busy          (busy),
    .done          (done),
    .err_cfg       (err_cfg),
    .err_sync      (err_sync)
  );

  always #5 clk = ~clk;

  // Activity monitor, sampled on the falling edge.
  logic       clr = 1'b1;
  int         cyc, n_win, n_acc, n_rdy, n_pad, n_done, n_ecfg, n_esync, n_leak, n_lbbad;
  int         fifth_cyc, first_win_cyc;
  logic [3:0] first_flags, last_flags, flags;
  assign flags = {win_first_row, win_last_row, win_first_col, win_last_col};

  always @(negedge clk) begin
    if (clr) begin
      cyc <= 0; n_win <= 0; n_acc <= 0; n_rdy <= 0; n_pad <= 0; n_done <= 0;
      n_ecfg <= 0; n_esync <= 0; n_leak <= 0; n_lbbad <= 0;
      fifth_cyc <= -100; first_win_cyc <= -1; first_flags <= '0; last_flags <= '0;
    end else begin
      cyc <= cyc + 1;
      if (pix.in_valid && pix.in_ready) begin
        n_acc <= n_acc + 1;
        if (n_acc == 4) fifth_cyc <= cyc;
      end
      if (pix.in_ready) n_rdy <= n_rdy + 1;
      if (lb_enable && pad_sel) n_pad <= n_pad + 1;
      if (lb_enable && !pad_sel && !(pix.in_valid && pix.in_ready)) n_lbbad <= n_lbbad + 1;
      if (done) n_done <= n_done + 1;
      if (err_cfg) n_ecfg <= n_ecfg + 1;
      if (err_sync) n_esync <= n_esync + 1;
      if (!win_valid && flags != 4'b0) n_leak <= n_leak + 1;
      if (win_valid) begin
        n_win <= n_win + 1;
        if (n_win == 0) begin
          first_flags   <= flags;
          first_win_cyc <= cyc;
        end
        last_flags <= flags;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    #1;
    clr = 1'b0;
    step();
  endtask

  task automatic start_frame(input int unsigned cols, input int unsigned rows);
    cfg_cols = CW'(cols);
    cfg_rows = RW'(rows);
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Feeds beats until done; optional misplaced sof, mid-frame start, or early abort.
  task automatic drive_frame(input bit toggle, input int sof_at, input int start_at,
                             input int abort_at);
    int beats = 0;
    bit acc;
    bit fin = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (beats == abort_at) return;
      pix.in_valid = toggle ? (c % 2 == 0) : 1'b1;
      pix.in_sof   = pix.in_valid && (beats == 0 || beats == sof_at);
      start        = (c == start_at);
      if (c == start_at) begin
        cfg_cols = CW'(6);
        cfg_rows = RW'(8);
      end
      @(negedge clk);
      acc = pix.in_valid && pix.in_ready;
      #1;
      if (n_done > 0) begin
        fin = 1'b1;
      end else begin
        step();
        if (acc) begin
          if (sof_at > 0 && beats == sof_at) begin
            check("sof_err_pulse", 32'(err_sync), 32'd1);
            check("sof_row_restart", 32'(dut.row_cnt), 32'd0);
            check("sof_col_restart", 32'(dut.col_cnt), 32'd1);
            check("sof_in_ready", 32'(pix.in_ready), 32'd1);
            check("sof_no_window", 32'(win_valid), 32'd0);
            beats  = 1;
            sof_at = -1;
          end else begin
            beats++;
          end
        end
      end
    end
    if (!fin) check("frame_timeout_done", 32'(n_done), 32'd1);
    pix.in_valid = 1'b0;
    pix.in_sof   = 1'b0;
    start        = 1'b0;
  endtask

  initial begin
    pix.in_valid = 1'b0;
    pix.in_sof   = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("reset_outs", 32'({pix.in_ready, lb_enable, pad_sel, win_valid, flags,
                             busy, done, err_cfg, err_sync}), 32'd0);
    check("reset_tap", 32'(lb_tap_N), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    clear_mon();

    // 4x4 frame, continuous input
    start_frame(4, 4);
    check("c_busy", 32'(busy), 32'd1);
    check("c_tap", 32'(lb_tap_N), 32'd2);
    drive_frame(1'b0, -1, -1, -1);
    step();
    check("c_win_count", 32'(n_win), 32'd16);
    check("c_ready_cycles", 32'(n_rdy), 32'd16);
    check("c_flush_pad", 32'(n_pad), 32'd4);
    check("c_done_count", 32'(n_done), 32'd1);
    check("c_first_win_lat", 32'(first_win_cyc), 32'(fifth_cyc + 1));
    check("c_first_flags", 32'(first_flags), 32'b1010);
    check("c_last_flags", 32'(last_flags), 32'b0101);
    check("c_flag_leak", 32'(n_leak), 32'd0);
    check("c_idle_busy", 32'(busy), 32'd0);

    // 4x4 frame, valid every other cycle
    clear_mon();
    start_frame(4, 4);
    drive_frame(1'b1, -1, -1, -1);
    step();
    check("t_win_count", 32'(n_win), 32'd16);
    check("t_accepted", 32'(n_acc), 32'd16);
    check("t_lb_unaccepted", 32'(n_lbbad), 32'd0);
    check("t_flush_pad", 32'(n_pad), 32'd4);
    check("t_first_win_lat", 32'(first_win_cyc), 32'(fifth_cyc + 1));
    check("t_first_flags", 32'(first_flags), 32'b1010);
    check("t_last_flags", 32'(last_flags), 32'b0101);
    check("t_flag_leak", 32'(n_leak), 32'd0);
    check("t_done_count", 32'(n_done), 32'd1);

    // Rejected configurations
    start_frame(1, 4);
    check("cfg_cols1_err", 32'(err_cfg), 32'd1);
    check("cfg_cols1_busy", 32'(busy), 32'd0);
    step();
    check("cfg_err_one_cycle", 32'(err_cfg), 32'd0);
    start_frame(4, 1);
    check("cfg_rows1_err", 32'(err_cfg), 32'd1);
    check("cfg_rows1_busy", 32'(busy), 32'd0);
    start_frame(DEPTH + 1, 4);
    check("cfg_cols_over_err", 32'(err_cfg), 32'd1);
    start_frame(4, ROWS + 1);
    check("cfg_rows_over_err", 32'(err_cfg), 32'd1);
    check("cfg_rows_over_busy", 32'(busy), 32'd0);

    // Largest legal configuration is accepted, then abandoned by reset
    start_frame(DEPTH, ROWS);
    check("cfg_max_err", 32'(err_cfg), 32'd0);
    check("cfg_max_busy", 32'(busy), 32'd1);
    check("cfg_max_tap", 32'(lb_tap_N), 32'(DEPTH - 2));
    rst = 1'b0;
    #1;
    check("cfg_max_abort_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b1;

    // Smallest legal frame 2x2
    clear_mon();
    start_frame(2, 2);
    drive_frame(1'b0, -1, -1, -1);
    step();
    check("min_win_count", 32'(n_win), 32'd4);
    check("min_flush_pad", 32'(n_pad), 32'd2);
    check("min_done", 32'(n_done), 32'd1);

    // Misplaced sof at row 2 column 3: 7 windows before restart, 16 after
    clear_mon();
    start_frame(4, 4);
    drive_frame(1'b0, 11, -1, -1);
    step();
    check("sof_err_count", 32'(n_esync), 32'd1);
    check("sof_win_total", 32'(n_win), 32'd23);
    check("sof_done", 32'(n_done), 32'd1);

    // Reset in RUN abandons the frame
    clear_mon();
    start_frame(4, 4);
    drive_frame(1'b0, -1, -1, 8);
    check("rst_mid_running", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_outs", 32'({pix.in_ready, lb_enable, pad_sel, win_valid, flags,
                               busy, done, err_cfg, err_sync}), 32'd0);
    check("rst_mid_tap", 32'(lb_tap_N), 32'd0);
    pix.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("rst_mid_no_done", 32'(n_done), 32'd0);
    clear_mon();
    start_frame(4, 4);
    drive_frame(1'b0, -1, -1, -1);
    step();
    check("rst_after_win", 32'(n_win), 32'd16);
    check("rst_after_done", 32'(n_done), 32'd1);

    // start while busy is ignored
    clear_mon();
    start_frame(4, 4);
    drive_frame(1'b0, -1, 6, -1);
    step();
    check("busy_start_win", 32'(n_win), 32'd16);
    check("busy_start_tap", 32'(lb_tap_N), 32'd2);
    check("busy_start_cfgerr", 32'(n_ecfg), 32'd0);
    check("busy_start_done", 32'(n_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
